// File: rtl/esm_pkg.sv
// Shared definitions for the ESM instruction feeder.
//   - RV32I opcode constants used by the control decode
//   - FSM state encoding (IDLE, FETCH, DRAIN, DONE)
//   - decode_ctl(): opcode -> {RegWrite, ALUSrc}
package esm_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Returns {RegWrite, ALUSrc}. Unknown opcodes (including the all-zero
  // end-of-stream word) decode to no write and register operand.
  function automatic logic [1:0] decode_ctl(input logic [6:0] opc);
    logic [1:0] ctl;
    ctl = 2'b00;
    case (opc)
      OPC_R:      ctl = 2'b10;
      OPC_IMM:    ctl = 2'b11;
      OPC_LOAD:   ctl = 2'b11;
      OPC_STORE:  ctl = 2'b01;
      OPC_BRANCH: ctl = 2'b00;
      OPC_LUI:    ctl = 2'b11;
      OPC_AUIPC:  ctl = 2'b11;
      OPC_JAL:    ctl = 2'b10;
      OPC_JALR:   ctl = 2'b11;
      default:    ctl = 2'b00;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/esm_instr_feeder_if.sv
// Bus bundle between the feeder, its instruction ROM and the ESM consumer.
//   control : start, base_addr, instr_count (in)  busy, done, state (out)
//   ROM     : mem_en, mem_addr (out)  mem_rdata (in, valid the cycle after mem_en)
//   ESM     : Instr_out, RegWrite, ALUSrc (out)  hold (in)
// Handshake: there is no valid/ready pair. A ROM read is issued on every
// edge where mem_en=1 and its data is consumed on the following edge. The
// ESM side is "always valid": a new word (or a zero bubble) is presented on
// every edge where hold=0; with hold=1 the output words stay frozen.
// master = feeder side, slave = environment side.
interface esm_instr_feeder_if #(
  parameter int Instruction_word_size = 32,
  parameter int ADDR_W                = 8
) ();

  logic                             start;
  logic [ADDR_W-1:0]                base_addr;
  logic [ADDR_W:0]                  instr_count;
  logic                             hold;
  logic                             mem_en;
  logic [ADDR_W-1:0]                mem_addr;
  logic [Instruction_word_size-1:0] mem_rdata;
  logic [Instruction_word_size-1:0] Instr_out;
  logic                             RegWrite;
  logic                             ALUSrc;
  logic                             busy;
  logic                             done;
  esm_pkg::state_e                  state;

  modport master (
    input  start, base_addr, instr_count, hold, mem_rdata,
    output mem_en, mem_addr, Instr_out, RegWrite, ALUSrc, busy, done, state
  );

  modport slave (
    output start, base_addr, instr_count, hold, mem_rdata,
    input  mem_en, mem_addr, Instr_out, RegWrite, ALUSrc, busy, done, state
  );

endinterface

// File: rtl/esm_sync_fifo.sv
// Small synchronous FIFO used as the feeder's prefetch buffer.
//   clk, rst (async active-low), push/din, pop/dout (head, combinational),
//   count, full, empty. DEPTH must be a power of two, 2 or more, so the
//   pointers wrap naturally.
module esm_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/esm_instr_feeder.sv
// ESM instruction feeder: streams instr_count words from a synchronous ROM
// starting at base_addr into ESM, decoding RegWrite/ALUSrc from each opcode,
// then emits DRAIN_CYCLES+1 zero words (end-of-stream) before raising done.
//   clk, rst (async active-low) plain ports; everything else on bus (master).
// Pipeline: issue (mem_en) -> ROM data next edge pushed into the FIFO ->
// popped into the registered output stage when hold=0.
module esm_instr_feeder
  import esm_pkg::*;
#(
  parameter int Instruction_word_size = 32,
  parameter int ADDR_W                = 8,
  parameter int DEPTH                 = 4,
  parameter int DRAIN_CYCLES          = 20
) (
  input logic               clk,
  input logic               rst,
  esm_instr_feeder_if.master bus
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_e                           state_q;
  logic [ADDR_W-1:0]                addr_q;
  logic [ADDR_W:0]                  remaining_q;
  logic [DRAIN_W-1:0]               drain_cnt_q;
  logic                             inflight_q;
  logic [Instruction_word_size-1:0] instr_q;
  logic                             regwrite_q, alusrc_q;

  logic [Instruction_word_size-1:0] fifo_dout;
  logic [CNT_W-1:0]                 fifo_count;
  logic                             fifo_full, fifo_empty;
  logic [CNT_W:0]                   occupancy;
  logic                             issue, pop, last_pop;

  // Words already fetched or still on their way from the ROM; issuing only
  // below DEPTH guarantees the FIFO can never be pushed while full.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
  assign issue     = (state_q == FETCH) && (remaining_q != '0) &&
                     (occupancy < (CNT_W+1)'(DEPTH));
  assign pop       = !bus.hold && !fifo_empty;
  // Leave FETCH on the edge that pops the final word so the first drain
  // zero follows it directly with no bubble.
  assign last_pop  = (remaining_q == '0) && !inflight_q &&
                     (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

  esm_sync_fifo #(
    .WIDTH (Instruction_word_size),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   (bus.mem_rdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      drain_cnt_q <= '0;
      inflight_q  <= 1'b0;
      instr_q     <= '0;
      regwrite_q  <= 1'b0;
      alusrc_q    <= 1'b0;
    end else begin
      // Output stage: frozen under hold, otherwise head word or a bubble.
      if (!bus.hold) begin
        if (!fifo_empty) begin
          instr_q                  <= fifo_dout;
          {regwrite_q, alusrc_q}   <= decode_ctl(fifo_dout[6:0]);
        end else begin
          instr_q    <= '0;
          regwrite_q <= 1'b0;
          alusrc_q   <= 1'b0;
        end
      end

      inflight_q <= issue;
      if (issue) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end

      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            addr_q      <= bus.base_addr;
            remaining_q <= bus.instr_count;
            drain_cnt_q <= '0;
            state_q     <= (bus.instr_count == '0) ? DRAIN : FETCH;
          end
        end
        FETCH: begin
          if (last_pop) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!bus.hold) begin
            if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES)) state_q <= DONE;
            else drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = issue;
  assign bus.mem_addr  = addr_q;
  assign bus.Instr_out = instr_q;
  assign bus.RegWrite  = regwrite_q;
  assign bus.ALUSrc    = alusrc_q;
  assign bus.busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.state     = state_q;

  // The FIFO's full flag is implied by the occupancy accounting above.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_esm_instr_feeder.sv
module tb_esm_instr_feeder;
  import esm_pkg::*;

  localparam int W = 34;  // {RegWrite, ALUSrc, Instr}

  logic clk;
  logic rst;

  esm_instr_feeder_if #(.Instruction_word_size(32), .ADDR_W(8)) ifc ();

  esm_instr_feeder #(
    .Instruction_word_size(32), .ADDR_W(8), .DEPTH(4), .DRAIN_CYCLES(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM model ----------------
  logic [31:0] rom [256];
  always @(posedge clk) begin
    if (ifc.mem_en) ifc.mem_rdata <= rom[ifc.mem_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [7:0]   addr_log[$];
  int checks = 0;
  int errors = 0;
  int issued, popped, max_out;
  logic pre_en, pre_hold;
  logic [7:0] pre_addr;

  function automatic logic [1:0] ref_ctl(input logic [31:0] w);
    case (w[6:0])
      7'h33:                          return 2'b10;
      7'h13, 7'h03, 7'h37, 7'h17, 7'h67: return 2'b11;
      7'h23:                          return 2'b01;
      7'h6F:                          return 2'b10;
      default:                        return 2'b00;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge: captures what the next rising edge sees,
  // crosses it, and returns at the following falling edge.
  task automatic tick();
    #4;
    pre_en   = ifc.mem_en;
    pre_addr = ifc.mem_addr;
    pre_hold = ifc.hold;
    if (pre_en) begin
      issued++;
      addr_log.push_back(pre_addr);
    end
    @(posedge clk);
    @(negedge clk);
    if (!pre_hold && ifc.Instr_out != 32'h0) popped++;
    if (issued - popped > max_out) max_out = issued - popped;
  endtask

  task automatic start_stream(input logic [7:0] base, input logic [8:0] cnt);
    exp_q.delete();
    got_q.delete();
    addr_log.delete();
    issued = 0; popped = 0; max_out = 0;
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] w;
      w = rom[8'(base + 8'(i))];
      exp_q.push_back({ref_ctl(w), w});
    end
    ifc.start = 1'b1;
    ifc.base_addr = base;
    ifc.instr_count = cnt;
    tick();  // E0
    ifc.start = 1'b0;
  endtask

  // Runs until done (or budget), recording each word the DUT outputs.
  task automatic run_to_done(input int budget, input int hlo, input int hhi,
                             output bit timed_out);
    timed_out = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      ifc.hold = (c >= hlo && c <= hhi);
      tick();
      if (!pre_hold && ifc.Instr_out != 32'h0)
        got_q.push_back({ifc.RegWrite, ifc.ALUSrc, ifc.Instr_out});
      if (ifc.done) begin
        timed_out = 1'b0;
        break;
      end
    end
    ifc.hold = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if ({ifc.Instr_out, ifc.RegWrite, ifc.ALUSrc} !== 34'h0) begin
      errors++; $display("FAIL reset_out got %h exp 0", {ifc.Instr_out, ifc.RegWrite, ifc.ALUSrc}); end
    checks++; if ({ifc.busy, ifc.done, ifc.mem_en} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {ifc.busy, ifc.done, ifc.mem_en}); end
    checks++; if (ifc.state !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d exp %0d", ifc.state, IDLE); end
    rst = 1'b1;
    tick();
    checks++; if (ifc.state !== IDLE) begin
      errors++; $display("FAIL idle_no_start got %0d exp %0d", ifc.state, IDLE); end
  endtask

  task automatic test_basic();
    logic [W-1:0] e, g;
    start_stream(8'h00, 9'd3);
    checks++; if (ifc.busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %b exp 1", ifc.busy); end
    for (int c = 1; c <= 26; c++) begin
      tick();
      g = {ifc.RegWrite, ifc.ALUSrc, ifc.Instr_out};
      e = (c >= 3 && c <= 5) ? exp_q.pop_front() : 34'h0;
      checks++; if (g !== e) begin
        errors++; $display("FAIL basic_out_E%0d got %h exp %h", c, g, e); end
      checks++; if (ifc.done !== (c == 26)) begin
        errors++; $display("FAIL basic_done_E%0d got %b exp %b", c, ifc.done, (c == 26)); end
    end
    checks++; if (ifc.busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_end got %b exp 0", ifc.busy); end
    checks++; if (addr_log.size() !== 3 || addr_log[0] !== 8'h00 || addr_log[2] !== 8'h02) begin
      errors++; $display("FAIL basic_addrs got %0d reads exp 3 (0..2)", addr_log.size()); end
  endtask

  task automatic test_hold();
    bit to;
    logic [W-1:0] e, g;
    start_stream(8'h10, 9'd8);
    run_to_done(80, 5, 8, to);
    checks++; if (to !== 1'b0) begin
      errors++; $display("FAIL hold_timeout got timeout exp done"); end
    checks++; if (max_out !== 4) begin
      errors++; $display("FAIL hold_outstanding got %0d exp 4", max_out); end
    checks++; if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL hold_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin
        errors++; $display("FAIL hold_word got %h exp %h", g, e); end
    end
  endtask

  task automatic test_zero_count();
    start_stream(8'h40, 9'd0);
    for (int c = 1; c <= 21; c++) begin
      tick();
      checks++; if ({ifc.Instr_out, ifc.done} !== {32'h0, (c == 21)}) begin
        errors++; $display("FAIL zero_E%0d got %h/%b exp 0/%b", c, ifc.Instr_out, ifc.done, (c == 21)); end
    end
    checks++; if (issued !== 0) begin
      errors++; $display("FAIL zero_mem_en got %0d reads exp 0", issued); end
  endtask

  task automatic test_wrap();
    bit to;
    logic [W-1:0] e, g;
    logic [7:0] exp_addr [4];
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    start_stream(8'hFE, 9'd4);
    run_to_done(60, 1000, 0, to);
    checks++; if (to !== 1'b0 || addr_log.size() !== 4) begin
      errors++; $display("FAIL wrap_reads got %0d exp 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++; if (addr_log[i] !== exp_addr[i]) begin
        errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, addr_log[i], exp_addr[i]); end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin
        errors++; $display("FAIL wrap_word got %h exp %h", g, e); end
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    logic [W-1:0] e, g;
    start_stream(8'h20, 9'd10);
    for (int c = 1; c <= 4; c++) tick();
    checks++; if (ifc.Instr_out !== rom[8'h21]) begin
      errors++; $display("FAIL mrst_pre got %h exp %h", ifc.Instr_out, rom[8'h21]); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({ifc.Instr_out, ifc.RegWrite, ifc.ALUSrc, ifc.busy, ifc.done, ifc.mem_en} !== 37'h0) begin
      errors++; $display("FAIL mrst_async got %h/%b%b%b%b%b exp 0", ifc.Instr_out,
        ifc.RegWrite, ifc.ALUSrc, ifc.busy, ifc.done, ifc.mem_en); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    issued = 0;
    for (int c = 0; c < 3; c++) tick();
    checks++; if ({ifc.state, ifc.busy, ifc.Instr_out} !== {IDLE, 1'b0, 32'h0} || issued !== 0) begin
      errors++; $display("FAIL mrst_idle got state %0d busy %b reads %0d exp IDLE 0 0",
        ifc.state, ifc.busy, issued); end
    start_stream(8'h00, 9'd3);
    run_to_done(60, 1000, 0, to);
    checks++; if (to !== 1'b0 || got_q.size() !== 3) begin
      errors++; $display("FAIL mrst_count got %0d exp 3", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin
        errors++; $display("FAIL mrst_word got %h exp %h", g, e); end
    end
  endtask

  task automatic test_start_busy();
    bit to;
    logic [W-1:0] e, g;
    start_stream(8'h00, 9'd3);
    tick();  // E1
    ifc.start = 1'b1; ifc.base_addr = 8'h64; ifc.instr_count = 9'd9;
    tick();  // E2
    ifc.start = 1'b0;
    run_to_done(60, 1000, 0, to);
    checks++; if (to !== 1'b0 || addr_log.size() !== 3 || addr_log[2] !== 8'h02) begin
      errors++; $display("FAIL busy_start_reads got %0d exp 3 (0..2)", addr_log.size()); end
    checks++; if (got_q.size() !== 3) begin
      errors++; $display("FAIL busy_start_count got %0d exp 3", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin
        errors++; $display("FAIL busy_start_word got %h exp %h", g, e); end
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    logic [6:0] opcs [10];
    logic [31:0] r;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      rom[i] = {r[31:7], opcs[$urandom_range(0, 9)]};
    end
    rom[0] = 32'h00A00093;
    rom[1] = 32'h002081B3;
    rom[2] = 32'h00A2E063;
    ifc.start = 1'b0;
    ifc.base_addr = '0;
    ifc.instr_count = '0;
    ifc.hold = 1'b0;
    rst = 1'b0;

    test_reset();
    test_basic();
    test_hold();
    test_zero_count();
    test_wrap();
    test_mid_reset();
    test_start_busy();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
